gcd_seq_client: RTL and testbench
=================================

Name: gcd_seq_client

Overview:
- Initiator-side block for the GCD request/response interface. Computes the GCD of a variable-length stream of operands.
- For each operand after the first, issues one request {acc, x} to an external GCD server, then waits for that server's response.
- Sits between an operand source and a result sink. The GCD unit is the server it talks to; in the test harness that server can be any GCD implementation.
- Exactly one request is outstanding at a time.

Parameters:
- p_nbits, 16, operand/result width. The request message is 2*p_nbits wide.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_msg  input  p_nbits+1  bit [p_nbits] = last flag; [p_nbits-1:0] = operand
- in_val  input  1  operand valid
- in_rdy  output  1  operand ready
- gcdreq_msg  output  2*p_nbits  {a, b}; a in upper half = accumulator, b in lower half = operand
- gcdreq_val  output  1  request valid
- gcdreq_rdy  input  1  server ready
- gcdresp_msg  input  p_nbits  gcd(a,b) from server
- gcdresp_val  input  1  response valid
- gcdresp_rdy  output  1  response ready
- out_msg  output  p_nbits  final GCD of the sequence
- out_val  output  1  result valid
- out_rdy  input  1  result sink ready

Behaviour:
- Handshakes: a transfer happens on a rising clk edge with val && rdy. All outputs are decoded from state and registers only; there are no combinational val->rdy paths.
- Registers: acc (p_nbits), opnd (p_nbits), last_r (1), state.
- Reset: state = IDLE. acc, opnd and last_r are cleared to 0. in_rdy=1, gcdreq_val=0, gcdresp_rdy=0, out_val=0. gcdreq_msg and out_msg read as 0.
- Reset asserted mid-sequence aborts the sequence: the partial acc is discarded and the state machine returns to IDLE next cycle.
- Reset does not cancel a request the server already accepted. The environment must reset the server at the same time.
- State machine:
  - IDLE: in_rdy=1. On in handshake: acc<=operand, last_r<=last. Go to DONE if last, else WAIT_IN.
  - WAIT_IN: in_rdy=1. On in handshake: opnd<=operand, last_r<=last. Go to REQ.
  - REQ: gcdreq_val=1, gcdreq_msg={acc, opnd}. On gcdreq_rdy go to RESP.
  - RESP: gcdresp_rdy=1. On gcdresp_val: acc<=gcdresp_msg. Go to DONE if last_r, else WAIT_IN.
  - DONE: out_val=1, out_msg=acc. On out_rdy go to IDLE.
- Single-element sequence (last set on the first operand) issues no GCD request and reports out_msg = the operand.
- Zero operands are forwarded unchanged to the server; gcd(0,0)=0 is the server's responsibility.
- A request is issued for every operand after the first, including operands equal to acc.
- Latency with zero-delay server and sink:
  - IDLE->DONE for a single element: 1 cycle after accepting the operand.
  - Each additional operand: 1 cycle WAIT_IN + ≥1 cycle REQ + server latency + 1 cycle RESP.
- gcdresp_val asserted outside RESP is not consumed, because gcdresp_rdy=0.
- gcdreq_val held high in REQ until accepted; gcdreq_msg stable while held.
- out_val held high in DONE until accepted; out_msg stable while held.
- in_rdy=0 in REQ, RESP and DONE, so the source is back-pressured.
- Line trace shows state, in transfer, request/response transfers and out transfer, matching the existing source/unit/sink trace style.

Test Plan:
- Operands 12, 18, 30(last); all delays 0 -> requests {12,18} then {6,30}; server responses 6, 6; out_msg=6 exactly once.
- Single operand 7(last) -> no gcdreq_val pulse; out_msg=7 one cycle after the in handshake.
- Operands 0, 0(last) -> request {0,0}; out_msg=0. Operands 16'hffff, 16'h00ff(last) -> out_msg=16'h00ff.
- Random server delay (max 5), random sink delay (max 10), random source delay (max 3) across three back-to-back sequences: (27,15,9)->3, (21,49)->7, (250,190,5)->5. All results match in order, and a server holding gcdreq_rdy low keeps gcdreq_msg stable.
- Reset asserted for 2 cycles while in RESP of sequence (40, 100, 60) -> out_val never asserts for that sequence. Next sequence (25,30 last) after reset and a fresh server yields out_msg=5.
- gcdresp_val forced high while in WAIT_IN -> gcdresp_rdy stays 0, acc unchanged, and the final result is still correct.

Source files
------------

// File: rtl/gcd_seq_client.sv
// Initiator that folds a stream of operands into one GCD by issuing one
// {acc, operand} request at a time to an external GCD server.
module gcd_seq_client #(
  parameter int p_nbits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [p_nbits:0]     in_msg,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [2*p_nbits-1:0] gcdreq_msg,
  output logic                 gcdreq_val,
  input  logic                 gcdreq_rdy,
  input  logic [p_nbits-1:0]   gcdresp_msg,
  input  logic                 gcdresp_val,
  output logic                 gcdresp_rdy,
  output logic [p_nbits-1:0]   out_msg,
  output logic                 out_val,
  input  logic                 out_rdy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_REQ     = 3'd2,
    ST_RESP    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [p_nbits-1:0] acc_r;
  logic [p_nbits-1:0] opnd_r;
  logic               last_r;
  logic [p_nbits-1:0] acc_next_s;
  logic [p_nbits-1:0] opnd_next_s;
  logic               last_next_s;

  logic               in_rdy_r;
  logic               gcdreq_val_r;
  logic               gcdresp_rdy_r;
  logic               out_val_r;

  logic [p_nbits-1:0] in_opnd_s;
  logic               in_last_s;
  logic               in_fire_s;
  logic               req_fire_s;
  logic               resp_fire_s;
  logic               out_fire_s;

  assign in_opnd_s   = in_msg[p_nbits-1:0];
  assign in_last_s   = in_msg[p_nbits];

  // Handshakes qualify only with registered ready/valid, so no val->rdy path exists
  assign in_fire_s   = in_val && in_rdy_r;
  assign req_fire_s  = gcdreq_val_r && gcdreq_rdy;
  assign resp_fire_s = gcdresp_val && gcdresp_rdy_r;
  assign out_fire_s  = out_val_r && out_rdy;

  // Next-state and datapath update selection
  always_comb begin
    next_state_s = state_r;
    acc_next_s   = acc_r;
    opnd_next_s  = opnd_r;
    last_next_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (in_fire_s) begin
          acc_next_s   = in_opnd_s;
          last_next_s  = in_last_s;
          next_state_s = in_last_s ? ST_DONE : ST_WAIT_IN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT_IN: begin
        if (in_fire_s) begin
          opnd_next_s  = in_opnd_s;
          last_next_s  = in_last_s;
          next_state_s = ST_REQ;
        end else begin
          next_state_s = ST_WAIT_IN;
        end
      end
      ST_REQ: begin
        if (req_fire_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (resp_fire_s) begin
          acc_next_s   = gcdresp_msg;
          next_state_s = last_r ? ST_DONE : ST_WAIT_IN;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      ST_DONE: begin
        if (out_fire_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        // Unused encodings recover to IDLE and drop any partial result
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and handshake-output registers; handshakes decoded from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      acc_r         <= {p_nbits{1'b0}};
      opnd_r        <= {p_nbits{1'b0}};
      last_r        <= 1'b0;
      in_rdy_r      <= 1'b1;
      gcdreq_val_r  <= 1'b0;
      gcdresp_rdy_r <= 1'b0;
      out_val_r     <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      acc_r         <= acc_next_s;
      opnd_r        <= opnd_next_s;
      last_r        <= last_next_s;
      in_rdy_r      <= (next_state_s == ST_IDLE) || (next_state_s == ST_WAIT_IN);
      gcdreq_val_r  <= (next_state_s == ST_REQ);
      gcdresp_rdy_r <= (next_state_s == ST_RESP);
      out_val_r     <= (next_state_s == ST_DONE);
    end
  end

  // acc/opnd are frozen in REQ and DONE, so both messages stay stable while held
  assign in_rdy      = in_rdy_r;
  assign gcdreq_val  = gcdreq_val_r;
  assign gcdreq_msg  = {acc_r, opnd_r};
  assign gcdresp_rdy = gcdresp_rdy_r;
  assign out_val     = out_val_r;
  assign out_msg     = acc_r;

endmodule

// File: tb/tb_gcd_seq_client.sv
// Directed bench for gcd_seq_client with a behavioural GCD server, a
// variable-delay sink and an in-line operand source.
module tb_gcd_seq_client;

  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NB:0]     in_msg = '0;
  logic            in_val = 1'b0;
  logic            in_rdy;
  logic [2*NB-1:0] gcdreq_msg;
  logic            gcdreq_val;
  logic            gcdreq_rdy;
  logic [NB-1:0]   gcdresp_msg;
  logic            gcdresp_val;
  logic            gcdresp_rdy;
  logic [NB-1:0]   out_msg;
  logic            out_val;
  logic            out_rdy = 1'b0;

  always #5 clk = ~clk;

  gcd_seq_client #(.p_nbits(NB)) dut (
    .clk(clk), .reset(reset),
    .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy),
    .gcdreq_msg(gcdreq_msg), .gcdreq_val(gcdreq_val), .gcdreq_rdy(gcdreq_rdy),
    .gcdresp_msg(gcdresp_msg), .gcdresp_val(gcdresp_val), .gcdresp_rdy(gcdresp_rdy),
    .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy)
  );

  int checks = 0;
  int fails  = 0;

  // environment knobs, written only by the main sequence
  logic        srv_reset = 1'b1;
  int unsigned srv_lo = 0, srv_hi = 0, sink_max = 0, src_max = 0;
  logic        force_val = 1'b0;

  // server state
  logic [1:0]      srv_st = 2'd0;
  logic            srv_req_rdy = 1'b0;
  logic            srv_resp_val = 1'b0;
  logic [NB-1:0]   srv_resp_msg = '0;
  logic [NB-1:0]   srv_a = '0, srv_b = '0;
  int unsigned     srv_wait = 0;
  logic [2*NB-1:0] req_q[$];

  // sink and monitor state
  int unsigned   sink_wait = 0;
  logic [NB-1:0] out_q[$];
  logic          hold_prev = 1'b0;
  logic [2*NB-1:0] msg_prev = '0;
  int            stable_err = 0, hold_cycles = 0, req_val_cycles = 0, out_val_cycles = 0;

  assign gcdreq_rdy  = srv_req_rdy;
  assign gcdresp_val = srv_resp_val | force_val;
  assign gcdresp_msg = force_val ? 16'hbeef : srv_resp_msg;

  function automatic logic [NB-1:0] gcd_fn(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NB-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // GCD server: accept, wait, respond
  always @(posedge clk) begin
    if (srv_reset) begin
      srv_st <= 2'd0; srv_req_rdy <= 1'b0; srv_resp_val <= 1'b0; srv_wait <= 0;
    end else begin
      case (srv_st)
        2'd0: begin
          if (srv_req_rdy && gcdreq_val) begin
            req_q.push_back(gcdreq_msg);
            srv_a <= gcdreq_msg[2*NB-1:NB];
            srv_b <= gcdreq_msg[NB-1:0];
            srv_req_rdy <= 1'b0;
            srv_wait <= $urandom_range(srv_hi, srv_lo);
            srv_st <= 2'd1;
          end else if (srv_wait != 0) begin
            srv_wait <= srv_wait - 1; srv_req_rdy <= 1'b0;
          end else begin
            srv_req_rdy <= 1'b1;
          end
        end
        2'd1: begin
          if (srv_wait != 0) srv_wait <= srv_wait - 1;
          else begin
            srv_resp_val <= 1'b1; srv_resp_msg <= gcd_fn(srv_a, srv_b); srv_st <= 2'd2;
          end
        end
        2'd2: begin
          if (srv_resp_val && gcdresp_rdy) begin
            srv_resp_val <= 1'b0; srv_wait <= $urandom_range(srv_hi, srv_lo); srv_st <= 2'd0;
          end
        end
        default: srv_st <= 2'd0;
      endcase
    end
  end

  // result sink with random back-pressure
  always @(posedge clk) begin
    if (out_val && out_rdy) begin
      out_q.push_back(out_msg);
      sink_wait <= (sink_max == 0) ? 0 : $urandom_range(sink_max, 1);
      out_rdy   <= (sink_max == 0);
    end else if (sink_wait != 0) begin
      sink_wait <= sink_wait - 1; out_rdy <= 1'b0;
    end else begin
      out_rdy <= 1'b1;
    end
  end

  // request-hold stability and activity counters
  always @(posedge clk) begin
    if (!reset && hold_prev && gcdreq_val && (gcdreq_msg != msg_prev)) stable_err <= stable_err + 1;
    hold_prev <= gcdreq_val && !gcdreq_rdy;
    msg_prev  <= gcdreq_msg;
    if (gcdreq_val && !gcdreq_rdy) hold_cycles <= hold_cycles + 1;
    if (gcdreq_val) req_val_cycles <= req_val_cycles + 1;
    if (out_val) out_val_cycles <= out_val_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [NB-1:0] op, input logic last);
    logic got;
    int unsigned n;
    got = 1'b0;
    n = (src_max == 0) ? 0 : $urandom_range(src_max, 0);
    repeat (n) tick();
    in_msg = {last, op};
    in_val = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      got = in_rdy;
      tick();
    end
    in_val = 1'b0;
    chk("in_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_outs(input int n);
    for (int i = 0; i < 600 && out_q.size() < n; i++) tick();
    repeat (4) tick();
    chk("out_count", out_q.size(), n);
  endtask

  initial begin
    int o0, r0, v0, h0;
    logic got;

    // reset state
    reset = 1'b1; srv_reset = 1'b1;
    repeat (2) tick();
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("rst_req_val", {31'd0, gcdreq_val}, 32'd0);
    chk("rst_resp_rdy", {31'd0, gcdresp_rdy}, 32'd0);
    chk("rst_out_val", {31'd0, out_val}, 32'd0);
    chk("rst_req_msg", gcdreq_msg, 32'd0);
    chk("rst_out_msg", {16'd0, out_msg}, 32'd0);
    reset = 1'b0; srv_reset = 1'b0;
    tick();

    // 12, 18, 30 with zero delays
    o0 = out_q.size(); r0 = req_q.size();
    send(16'd12, 1'b0); send(16'd18, 1'b0); send(16'd30, 1'b1);
    wait_outs(o0 + 1);
    chk("t1_req_count", req_q.size(), r0 + 2);
    chk("t1_req0", req_q[r0], {16'd12, 16'd18});
    chk("t1_req1", req_q[r0+1], {16'd6, 16'd30});
    chk("t1_out", {16'd0, out_q[o0]}, 32'd6);

    // single operand: no request, result one cycle after the handshake
    o0 = out_q.size(); v0 = req_val_cycles;
    send(16'd7, 1'b1);
    chk("t2_out_val", {31'd0, out_val}, 32'd1);
    chk("t2_out_msg", {16'd0, out_msg}, 32'd7);
    wait_outs(o0 + 1);
    chk("t2_out", {16'd0, out_q[o0]}, 32'd7);
    chk("t2_no_req", req_val_cycles, v0);

    // zero operands
    o0 = out_q.size(); r0 = req_q.size();
    send(16'd0, 1'b0); send(16'd0, 1'b1);
    wait_outs(o0 + 1);
    chk("t3_req", req_q[r0], 32'd0);
    chk("t3_out", {16'd0, out_q[o0]}, 32'd0);

    // extreme values
    o0 = out_q.size();
    send(16'hffff, 1'b0); send(16'h00ff, 1'b1);
    wait_outs(o0 + 1);
    chk("t4_out", {16'd0, out_q[o0]}, 32'h00ff);

    // fixed slow server forces the request to be held
    srv_lo = 4; srv_hi = 4;
    o0 = out_q.size(); h0 = hold_cycles;
    send(16'hffff, 1'b0); send(16'h00ff, 1'b0); send(16'h0033, 1'b1);
    wait_outs(o0 + 1);
    chk("t5_out", {16'd0, out_q[o0]}, 32'h0033);
    chk("t5_held", {31'd0, (hold_cycles > h0)}, 32'd1);
    chk("t5_stable", stable_err, 0);

    // random delays, three back-to-back sequences
    srv_lo = 0; srv_hi = 5; sink_max = 10; src_max = 3;
    o0 = out_q.size();
    send(16'd27, 1'b0); send(16'd15, 1'b0); send(16'd9, 1'b1);
    send(16'd21, 1'b0); send(16'd49, 1'b1);
    send(16'd250, 1'b0); send(16'd190, 1'b0); send(16'd5, 1'b1);
    wait_outs(o0 + 3);
    chk("t6_out0", {16'd0, out_q[o0]}, 32'd3);
    chk("t6_out1", {16'd0, out_q[o0+1]}, 32'd7);
    chk("t6_out2", {16'd0, out_q[o0+2]}, 32'd5);
    chk("t6_stable", stable_err, 0);

    // reset while in RESP aborts the sequence
    srv_lo = 8; srv_hi = 8; sink_max = 0; src_max = 0;
    repeat (12) tick();
    o0 = out_q.size(); v0 = out_val_cycles;
    send(16'd40, 1'b0); send(16'd100, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      got = gcdresp_rdy;
      if (!got) tick();
    end
    chk("t7_in_resp", {31'd0, got}, 32'd1);
    reset = 1'b1; srv_reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0; srv_reset = 1'b0; srv_lo = 0; srv_hi = 0;
    chk("t7_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("t7_resp_rdy", {31'd0, gcdresp_rdy}, 32'd0);
    repeat (5) tick();
    chk("t7_no_out_val", out_val_cycles, v0);
    chk("t7_no_out", out_q.size(), o0);
    send(16'd25, 1'b0); send(16'd30, 1'b1);
    wait_outs(o0 + 1);
    chk("t7_out", {16'd0, out_q[o0]}, 32'd5);

    // spurious response while waiting for an operand
    o0 = out_q.size(); r0 = req_q.size();
    send(16'd20, 1'b0);
    force_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t8_resp_rdy", {31'd0, gcdresp_rdy}, 32'd0);
      chk("t8_acc", {16'd0, gcdreq_msg[2*NB-1:NB]}, 32'd20);
    end
    force_val = 1'b0;
    send(16'd30, 1'b1);
    wait_outs(o0 + 1);
    chk("t8_req", req_q[r0], {16'd20, 16'd30});
    chk("t8_out", {16'd0, out_q[o0]}, 32'd10);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
